// File: rtl/controller_cpu_mem_port_pkg.sv
// controller_cpu_mem_port_pkg: shared controller types and defaults for the CPU memory port
package controller_cpu_mem_port_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, RESP, ERR} state_e;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
endpackage

// File: rtl/controller_cpu_mem_port.sv
// controller_cpu_mem_port: CPU valid/ready bus to synchronous RAM core port with window decode
module controller_cpu_mem_port
  import controller_cpu_mem_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int ADDR_BITS = 14,
  parameter int READ_LATENCY = 1,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_valid,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_wstrb,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_error,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_d,
  output logic [3:0]           ram_bytesel,
  output logic                 ram_we,
  input  logic [31:0]          ram_q
);
  state_e state_q;
  logic [1:0] cnt_q;
  logic ready_q, error_q, we_q;
  logic [31:0] rdata_q, d_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [3:0] sel_q;
  logic in_win;
  logic unused_lsb;
  assign in_win = cpu_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
  assign unused_lsb = ^cpu_addr[1:0];
  assign cpu_ready = ready_q;
  assign cpu_error = error_q;
  assign cpu_rdata = rdata_q;
  assign ram_addr = addr_q;
  assign ram_d = d_q;
  assign ram_bytesel = sel_q;
  assign ram_we = we_q;
  // Response flags and the write strobe are pulses: cleared every edge unless re-armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      we_q <= 1'b0;
      rdata_q <= 32'd0;
      d_q <= 32'd0;
      addr_q <= '0;
      sel_q <= 4'd0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      we_q <= 1'b0;
      case (state_q)
        IDLE: if (cpu_valid) begin
          if (!in_win) begin
            state_q <= ERR;
            ready_q <= 1'b1;
            error_q <= 1'b1;
            rdata_q <= ERR_DATA;
          end else if (|cpu_wstrb) begin
            state_q <= WRITE;
            addr_q <= cpu_addr[ADDR_BITS+1:2];
            d_q <= cpu_wdata;
            sel_q <= cpu_wstrb;
            we_q <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            state_q <= READ_WAIT;
            addr_q <= cpu_addr[ADDR_BITS+1:2];
            sel_q <= 4'hF;
            cnt_q <= 2'(READ_LATENCY);
          end
        end
        WRITE, ERR: state_q <= RESP;
        READ_WAIT: if (cnt_q == 2'd0) begin
          rdata_q <= ram_q;
          ready_q <= 1'b1;
          state_q <= RESP;
        end else cnt_q <= cnt_q - 2'd1;
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
